// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: zero operands skip the iterations and finish in one cycle.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_value_i,
    input  logic [XLEN-1:0] rs2_value_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    // valid/ready: start_i is taken only in IDLE with flush_i low; done_o marks result_o/rd_addr_o valid for one cycle.
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d, rd_out_q, rd_out_d;
    logic [XLEN-1:0]   opnd_q, opnd_d, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d;

    logic              a_signed, b_signed, a_neg_i, b_neg_i;
    logic [XLEN-1:0]   a_mag_i, b_mag_i;
    logic [XLEN:0]     mul_sum, rem_sh, trial;
    logic [2*XLEN-1:0] mul_next, div_next, prod_s;
    logic [XLEN-1:0]   quo, rem, q_fix, r_fix, final_res;

    assign a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    assign b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    assign a_neg_i  = a_signed && rs1_value_i[XLEN-1];
    assign b_neg_i  = b_signed && rs2_value_i[XLEN-1];
    assign a_mag_i  = a_neg_i ? -rs1_value_i : rs1_value_i;
    assign b_mag_i  = b_neg_i ? -rs2_value_i : rs2_value_i;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign trial    = rem_sh - {1'b0, opnd_q};
    assign div_next = trial[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod_s = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    assign quo    = acc_q[XLEN-1:0];
    assign rem    = acc_q[2*XLEN-1:XLEN];
    // Signed magnitudes never exceed 2^(XLEN-1), so an all-ones quotient only comes from a zero divisor.
    assign q_fix  = ((a_neg_q ^ b_neg_q) && (quo != {XLEN{1'b1}})) ? -quo : quo;
    assign r_fix  = a_neg_q ? -rem : rem;

    always_comb begin
        final_res = r_fix;
        case (op_q)
            3'd0:                  final_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:      final_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:            final_res = q_fix;
            default:               final_res = r_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        acc_d    = acc_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        busy_o   = 1'b0;
        stall_o  = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    stall_o = 1'b1;
                    op_d    = op_i;
                    rd_d    = rd_addr_i;
                    a_neg_d = a_neg_i;
                    b_neg_d = b_neg_i;
                    cnt_d   = CNT_W'(XLEN);
                    state_d = S_RUN;
                    if (op_i[2]) begin
                        opnd_d = b_mag_i;
                        acc_d  = {{XLEN{1'b0}}, a_mag_i};
                    end else begin
                        opnd_d = a_mag_i;
                        acc_d  = {{XLEN{1'b0}}, b_mag_i};
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    if ((rs1_value_i == '0) || (rs2_value_i == '0)) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        acc_d   = (op_i[2] && (rs2_value_i == '0)) ? {a_mag_i, {XLEN{1'b1}}}
                                                                   : {(2*XLEN){1'b0}};
                    end
`endif
                end
            end
            S_RUN: begin
                busy_o  = 1'b1;
                stall_o = 1'b1;
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_o  = 1'b1;
                state_d = S_IDLE;
                if (!flush_i) begin
                    done_o   = 1'b1;
                    result_d = final_res;
                    rd_out_d = rd_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign result_o  = done_o ? final_res : result_q;
    assign rd_addr_o = done_o ? rd_q : rd_out_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            acc_q    <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table, random ops against a reference model, corner sequences.
module tb_ex_muldiv_unit;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_value_i, rs2_value_i;
    logic [4:0]  rd_addr_i;
    logic        busy_o, stall_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  exp_rd_q[$];
    logic [31:0] last_exp = '0;
    logic [4:0]  last_rd  = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;
    vec_t vecs[18];

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .rs1_value_i(rs1_value_i), .rs2_value_i(rs2_value_i), .rd_addr_i(rd_addr_i),
        .flush_i(flush_i), .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
        .result_o(result_o), .rd_addr_o(rd_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic signed [31:0] sa, sb, sq;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                sq = sa / sb; return sq;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                sq = sa % sb; return sq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (a == 0 || b == 0) return 1;
`endif
        return 33;
    endfunction

    // Issues one op in the current cycle and waits for its done_o; hold keeps start_i high throughout.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit hold);
        int lat;
        int c;
        bit got;
        bit stall_ok;
        lat = exp_lat(a, b);
        exp_q.push_back(exp);
        exp_rd_q.push_back(rd);
        start_i = 1'b1; op_i = op; rs1_value_i = a; rs2_value_i = b; rd_addr_i = rd;
        #1;
        chk("stall_issue", {31'b0, stall_o}, 32'd1);
        got = 0; stall_ok = 1; c = 0;
        while (!got && c < 60) begin
            tick();
            c++;
            if (!hold) start_i = 1'b0;
            rs1_value_i = $urandom; rs2_value_i = $urandom;
            #1;
            if (done_o) begin
                got = 1;
                chk("latency", c, lat);
                chk("stall_in_done", {31'b0, stall_o}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL scoreboard: done_o with no expected entry");
                end else begin
                    last_exp = exp_q.pop_front();
                    last_rd  = exp_rd_q.pop_front();
                    chk($sformatf("result op%0d %h %h", op, a, b), result_o, last_exp);
                    chk("rd_addr", {27'b0, rd_addr_o}, {27'b0, last_rd});
                end
            end else if (!stall_o || !busy_o) begin
                stall_ok = 0;
            end
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL timeout: no done_o within %0d cycles, expected %0d", c, lat);
            exp_q.delete(); exp_rd_q.delete();
        end
        chk("stall_busy_while_running", {31'b0, stall_ok}, 32'd1);
        tick();
        #1;
        chk("busy_after_done", {31'b0, busy_o}, 32'd0);
        chk("stall_after_done", {31'b0, stall_o}, {31'b0, hold});
        chk("result_held", result_o, last_exp);
    endtask

    initial begin
        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[7]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
        vecs[10] = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[11] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
        vecs[12] = '{3'd0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        vecs[13] = '{3'd5, 32'h0000_0000, 32'h0000_0007, 32'h0000_0000};
        vecs[14] = '{3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E};
        vecs[15] = '{3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002};
        vecs[16] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[17] = '{3'd4, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2};

        rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0;
        rs1_value_i = '0; rs2_value_i = '0; rd_addr_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        chk("reset_busy", {31'b0, busy_o}, 32'd0);
        chk("reset_stall", {31'b0, stall_o}, 32'd0);
        chk("reset_done", {31'b0, done_o}, 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_rd", {27'b0, rd_addr_o}, 32'd0);

        for (int i = 0; i < 18; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].res, 1'b0);

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_op(op, a, b, 5'($urandom_range(1, 31)), ref_res(op, a, b), 1'b0);
        end

        // start with flush in IDLE is ignored
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; rs1_value_i = 32'd3; rs2_value_i = 32'd4;
        #1;
        chk("flush_idle_stall", {31'b0, stall_o}, 32'd0);
        tick();
        chk("flush_idle_busy", {31'b0, busy_o}, 32'd0);
        start_i = 1'b0; flush_i = 1'b0;

        // reset at cycle 10 of a running op
        start_i = 1'b1; op_i = 3'd0; rs1_value_i = 32'd11; rs2_value_i = 32'd13; rd_addr_i = 5'd7;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start_i = 1'b0;
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_run_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_run_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_run_done", {31'b0, done_o}, 32'd0);
        chk("rst_run_result", result_o, 32'd0);
        chk("rst_run_rd", {27'b0, rd_addr_o}, 32'd0);
        run_op(3'd0, 32'd11, 32'd13, 5'd8, 32'd143, 1'b0);

        // flush at cycle 20 of a DIV
        start_i = 1'b1; op_i = 3'd4; rs1_value_i = 32'd1000; rs2_value_i = 32'd3; rd_addr_i = 5'd21;
        for (int c = 1; c < 20; c++) begin
            tick();
            start_i = 1'b0;
        end
        tick();
        flush_i = 1'b1;
        #1;
        chk("flush_run_stall", {31'b0, stall_o}, 32'd1);
        chk("flush_run_done", {31'b0, done_o}, 32'd0);
        tick();
        flush_i = 1'b0;
        #1;
        chk("flush_next_stall", {31'b0, stall_o}, 32'd0);
        chk("flush_next_busy", {31'b0, busy_o}, 32'd0);
        chk("flush_result_kept", result_o, last_exp);
        chk("flush_rd_kept", {27'b0, rd_addr_o}, {27'b0, last_rd});
        begin
            int seen = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (done_o) seen++;
            end
            chk("flush_no_done", seen, 0);
        end

        // start held high through DONE: re-accepted only once back in IDLE
        run_op(3'd0, 32'd3, 32'd5, 5'd9, 32'd15, 1'b1);
        run_op(3'd0, 32'd3, 32'd5, 5'd10, 32'd15, 1'b0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage. Consumes the forwarded rs1/rs2 operands (post forwarding-mux values) when a M-extension op issues. Holds the pipeline via stall_o until the result is ready, then presents result_o with its destination register for the EX/MEM register. One bit per cycle: shift-add multiply, restoring divide.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  issue request; sampled only in IDLE
op_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_value_i  input  XLEN  forwarded operand A (multiplicand/dividend)
rs2_value_i  input  XLEN  forwarded operand B (multiplier/divisor)
rd_addr_i  input  5  destination register of issuing op
flush_i  input  1  abort the in-flight op (branch/exception flush)
busy_o  output  1  high in RUN and DONE
stall_o  output  1  pipeline hold request to hazard logic
done_o  output  1  one-cycle pulse: result_o/rd_addr_o valid
result_o  output  XLEN  final result; held until next done_o
rd_addr_o  output  5  rd latched at issue

Behaviour:
- Reset: state IDLE, busy_o=0, stall_o=0, done_o=0, result_o=0, rd_addr_o=0, counter=0, internal accumulators=0.
- States: IDLE, RUN, DONE.
- IDLE: start_i=1 and flush_i=0 -> latch op, rd, operand magnitudes and sign flags; counter=XLEN; go RUN. start_i with flush_i=1 -> ignored.
- stall_o = (IDLE & start_i & ~flush_i) | RUN. Combinational so the issuing instruction is held in the same cycle it is presented. Deasserted in DONE.
- RUN: one iteration per cycle, counter decrements; on the cycle counter reaches 1, go DONE. RUN lasts exactly XLEN cycles.
- DONE: apply sign correction, register result_o, assert done_o for exactly one cycle, then IDLE. start_i in DONE is ignored; earliest next issue is the cycle after done_o.
- Latency: start accepted at cycle 0 -> done_o high at cycle XLEN+1 (33 for XLEN=32).
- Multiply: 2*XLEN-bit product of magnitudes. MULH signs both operands, MULHSU signs rs1 only, MULHU neither. MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of the correctly-signed product.
- Divide: DIV/REM signed, truncating toward zero. Remainder takes dividend sign.
- Divisor 0: quotient all ones (-1), remainder = dividend, for signed and unsigned forms. Still XLEN-cycle latency.
- Signed overflow (dividend -2^(XLEN-1), divisor -1): DIV -> -2^(XLEN-1), REM -> 0.
- flush_i in RUN or DONE: next state IDLE, done_o suppressed that cycle, result_o and rd_addr_o keep previous values.
- rst_i overrides flush_i and start_i in any state.
- Operand inputs are don't-care after the issue cycle.

Optional Feature:
MULDIV_EARLY_OUT_EN. Defined: in IDLE, an accepted start with rs1_value_i==0, or rs2_value_i==0 on a multiply op, or rs2_value_i==0 on a divide op goes directly to DONE (done_o at cycle 1), with results identical to the full path. stall_o is asserted for the issue cycle only. Undefined: every op takes XLEN cycles; no operand-zero comparators are built.

Test Plan:
- Reset in the middle of RUN (cycle 10): at the next edge state is IDLE and all outputs are 0; a new start is accepted on the following cycle.
- MUL with rs1=0x0000_0007, rs2=0xFFFF_FFFD -> done_o at cycle 33, result_o=0xFFFF_FFEB, stall_o high cycles 0-32, rd_addr_o = latched rd.
- MULH with 0x8000_0000 x 0x8000_0000 -> 0x4000_0000; MULHU with 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE; MULHSU with 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF; DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM of the same -> 0.
- DIVU 5/0 -> 0xFFFF_FFFF and REMU 5/0 -> 5, both at cycle 33; with MULDIV_EARLY_OUT_EN defined, the same results arrive at cycle 1.
- flush_i at cycle 20 of a DIV -> no done_o, result_o unchanged, stall_o low the next cycle; start_i held through DONE is not re-accepted until IDLE.
